// File: rtl/btn_event_gen_if.sv
// Button event bus: debounced level and enable in, single-cycle event pulses and held level out.
interface btn_event_gen_if;
  logic btn_lvl;
  logic en;
  logic press_pulse;
  logic rel_pulse;
  logic long_pulse;
  logic repeat_pulse;
  logic dbl_pulse;
  logic held;

  modport master (
    output btn_lvl, en,
    input  press_pulse, rel_pulse, long_pulse, repeat_pulse, dbl_pulse, held
  );

  modport slave (
    input  btn_lvl, en,
    output press_pulse, rel_pulse, long_pulse, repeat_pulse, dbl_pulse, held
  );
endinterface

// File: rtl/btn_event_gen.sv
// Turns a debounced button level into press/release/long/repeat pulses (all registered, 1 cycle).
// Define BTN_DBL_CLICK_EN to add the post-release GAP state and dbl_pulse on a quick second press.
module btn_event_gen #(
  parameter int CW       = 26,
  parameter int LONG_CYC = 50_000_000,
  parameter int REP_CYC  = 10_000_000,
  parameter int DBL_CYC  = 15_000_000
) (
  input  logic            cclk,
  input  logic            clr,
  btn_event_gen_if.slave  bus
);

  localparam int MAX_CYC = (LONG_CYC > REP_CYC) ?
                           ((LONG_CYC > DBL_CYC) ? LONG_CYC : DBL_CYC) :
                           ((REP_CYC  > DBL_CYC) ? REP_CYC  : DBL_CYC);

  if (MAX_CYC > (2 ** CW)) begin : g_cw_check
    $error("btn_event_gen: CW too narrow for the cycle thresholds");
  end

  localparam logic [CW-1:0] LONG_M1 = CW'(LONG_CYC - 1);
  localparam logic [CW-1:0] REP_M1  = CW'(REP_CYC - 1);

`ifdef BTN_DBL_CLICK_EN
  localparam logic [CW-1:0] DBL_M1  = CW'(DBL_CYC - 1);
  typedef enum logic [1:0] {S_IDLE, S_PRESS, S_REPEAT, S_GAP} state_t;
  localparam state_t S_AFTER_REL = S_GAP;
`else
  typedef enum logic [1:0] {S_IDLE, S_PRESS, S_REPEAT} state_t;
  localparam state_t S_AFTER_REL = S_IDLE;
`endif

  // FSM reset asserts with clr but releases two edges later, so btn_q has
  // already caught up with a held button and no false rise is seen.
  logic [1:0] rst_sync;
  logic       rst;

  always_ff @(posedge cclk or posedge clr) begin
    if (clr) rst_sync <= 2'b11;
    else     rst_sync <= {rst_sync[0], 1'b0};
  end
  assign rst = rst_sync[1];

  logic btn_q;
  always_ff @(posedge cclk or posedge clr) begin
    if (clr) btn_q <= 1'b0;
    else     btn_q <= bus.btn_lvl;
  end

  logic rise, fall;
  assign rise = bus.btn_lvl & ~btn_q;
  assign fall = ~bus.btn_lvl & btn_q;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          press_q, rel_q, long_q, rep_q, dbl_q;
  logic          press_nxt, rel_nxt, long_nxt, rep_nxt, dbl_nxt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    press_nxt = 1'b0;
    rel_nxt   = 1'b0;
    long_nxt  = 1'b0;
    rep_nxt   = 1'b0;
    dbl_nxt   = 1'b0;
    if (!bus.en) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (rise) begin
            press_nxt = 1'b1;
            cnt_nxt   = '0;
            state_nxt = S_PRESS;
          end
        end
        S_PRESS: begin
          if (fall) begin
            rel_nxt   = 1'b1;
            cnt_nxt   = '0;
            state_nxt = S_AFTER_REL;
          end else if (cnt == LONG_M1) begin
            long_nxt  = 1'b1;
            cnt_nxt   = '0;
            state_nxt = S_REPEAT;
          end else begin
            cnt_nxt   = cnt + CW'(1);
          end
        end
        S_REPEAT: begin
          if (fall) begin
            rel_nxt   = 1'b1;
            cnt_nxt   = '0;
            state_nxt = S_AFTER_REL;
          end else if (cnt == REP_M1) begin
            rep_nxt   = 1'b1;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt   = cnt + CW'(1);
          end
        end
`ifdef BTN_DBL_CLICK_EN
        S_GAP: begin
          // A rise on the window's last cycle is an ordinary press.
          if (rise) begin
            press_nxt = 1'b1;
            dbl_nxt   = (cnt != DBL_M1);
            cnt_nxt   = '0;
            state_nxt = S_PRESS;
          end else if (cnt == DBL_M1) begin
            cnt_nxt   = '0;
            state_nxt = S_IDLE;
          end else begin
            cnt_nxt   = cnt + CW'(1);
          end
        end
`endif
        default: begin
          cnt_nxt   = '0;
          state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge cclk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
      rep_q   <= 1'b0;
      dbl_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      press_q <= press_nxt;
      rel_q   <= rel_nxt;
      long_q  <= long_nxt;
      rep_q   <= rep_nxt;
      dbl_q   <= dbl_nxt;
    end
  end

  assign bus.press_pulse  = press_q;
  assign bus.rel_pulse    = rel_q;
  assign bus.long_pulse   = long_q;
  assign bus.repeat_pulse = rep_q;
  assign bus.held         = (state == S_PRESS) || (state == S_REPEAT);
`ifdef BTN_DBL_CLICK_EN
  assign bus.dbl_pulse    = dbl_q;
`else
  assign bus.dbl_pulse    = 1'b0;
  logic unused_dbl;
  assign unused_dbl = dbl_q;
`endif

endmodule

// File: tb/tb_btn_event_gen.sv
// Bench for btn_event_gen: vector table, hand sequences for the corner cases, random run vs. a timing model.
// Output vectors are packed {press, rel, long, repeat, dbl, held}.
module tb_btn_event_gen;
  localparam int LONG = 8;
  localparam int REP  = 4;
  localparam int DBL  = 6;

  logic cclk;
  logic clr;
  int   n_chk;
  int   n_err;

  btn_event_gen_if bif();

  btn_event_gen #(.CW(4), .LONG_CYC(LONG), .REP_CYC(REP), .DBL_CYC(DBL)) dut (
    .cclk (cclk),
    .clr  (clr),
    .bus  (bif.slave)
  );

  initial begin
    cclk = 1'b0;
    forever #5 cclk = ~cclk;
  end

  // Reference model: time-based view of a press (edges since press / since release).
  logic m_prev;
  logic m_active;
  int   m_hold;
  logic m_gap;
  int   m_gap_age;

  task automatic model_reset(input logic lvl);
    m_prev    = lvl;
    m_active  = 1'b0;
    m_hold    = 0;
    m_gap     = 1'b0;
    m_gap_age = 0;
  endtask

  task automatic model_step(input logic lvl, input logic e, output logic [5:0] ex);
    logic rise;
    logic p, r, l, rp, d;
    rise = lvl & ~m_prev;
    {p, r, l, rp, d} = 5'b0;
    if (!e) begin
      m_active = 1'b0;
      m_gap    = 1'b0;
    end else if (m_active) begin
      if (!lvl) begin
        r        = 1'b1;
        m_active = 1'b0;
`ifdef BTN_DBL_CLICK_EN
        m_gap     = 1'b1;
        m_gap_age = 0;
`endif
      end else begin
        m_hold = m_hold + 1;
        l  = (m_hold == LONG);
        rp = (m_hold > LONG) && (((m_hold - LONG) % REP) == 0);
      end
    end else begin
      if (m_gap) begin
        m_gap_age = m_gap_age + 1;
        if (m_gap_age >= DBL) m_gap = 1'b0;
      end
      if (rise) begin
        p        = 1'b1;
        d        = m_gap;
        m_gap    = 1'b0;
        m_active = 1'b1;
        m_hold   = 0;
      end
    end
    m_prev = lvl;
    ex = {p, r, l, rp, d, m_active};
  endtask

  function automatic logic [5:0] outv();
    return {bif.press_pulse, bif.rel_pulse, bif.long_pulse,
            bif.repeat_pulse, bif.dbl_pulse, bif.held};
  endfunction

  task automatic check(input string name, input logic [5:0] got, input logic [5:0] ex);
    n_chk = n_chk + 1;
    if (got !== ex) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, got, ex, $time);
    end
  endtask

  // One clock: drive inputs, let the edge happen, compare against the model.
  task automatic cycle(input logic lvl, input logic e);
    logic [5:0] ex;
    bif.btn_lvl = lvl;
    bif.en      = e;
    @(posedge cclk);
    #1;
    model_step(lvl, e, ex);
    check("model", outv(), ex);
  endtask

  task automatic do_reset(input logic lvl);
    bif.btn_lvl = lvl;
    bif.en      = 1'b1;
    clr = 1'b1;
    #1;
    check("rst_async", outv(), 6'b0);
    @(posedge cclk);
    #1;
    check("rst_held", outv(), 6'b0);
    #3 clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge cclk);
      #1;
      check("rst_release", outv(), 6'b0);
    end
    model_reset(lvl);
  endtask

  typedef struct {
    logic       lvl;
    logic       en;
    logic [5:0] ex;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic lvl, input logic e, input logic [5:0] ex);
    vec_t v;
    v.lvl = lvl;
    v.en  = e;
    v.ex  = ex;
    tbl.push_back(v);
  endfunction

  initial begin
    logic lvl;
    logic e;
    n_chk = 0;
    n_err = 0;
    clr = 1'b1;
    bif.btn_lvl = 1'b0;
    bif.en      = 1'b1;
    model_reset(1'b0);

    // Short press of 3 cycles: press, held x3, release.
    add(1, 1, 6'b100001); add(1, 1, 6'b000001); add(1, 1, 6'b000001);
    add(0, 1, 6'b010000); add(0, 1, 6'b000000);
    // Release on the cycle a long press would have fired.
    add(1, 1, 6'b100001);
    for (int i = 0; i < 7; i++) add(1, 1, 6'b000001);
    add(0, 1, 6'b010000); add(0, 1, 6'b000000);
    // Rise while disabled, then enable with the button still down: nothing.
    add(1, 0, 6'b000000); add(1, 1, 6'b000000); add(1, 1, 6'b000000);
    add(0, 1, 6'b000000); add(0, 1, 6'b000000);

    #1;
    check("reset_state", outv(), 6'b0);
    do_reset(1'b0);

    foreach (tbl[i]) begin
      cycle(tbl[i].lvl, tbl[i].en);
      check($sformatf("vec%0d", i), outv(), tbl[i].ex);
    end

    // Held 20 cycles past the press: long at +8, repeats at +12, +16, +20.
    for (int j = 0; j <= 20; j++) begin
      cycle(1'b1, 1'b1);
      check($sformatf("hold20_j%0d", j), outv(),
            {(j == 0), 1'b0, (j == 8), (j == 12 || j == 16 || j == 20), 1'b0, 1'b1});
    end
    cycle(1'b0, 1'b1);
    check("hold20_release", outv(), 6'b010000);
    cycle(1'b0, 1'b1);

    // Disable in REPEAT: everything stops, no release pulse, no re-press while still held.
    for (int j = 0; j < 14; j++) cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b0);
    check("en_off_0", outv(), 6'b000000);
    cycle(1'b1, 1'b0);
    check("en_off_1", outv(), 6'b000000);
    for (int j = 0; j < 3; j++) begin
      cycle(1'b1, 1'b1);
      check("en_back_held", outv(), 6'b000000);
    end
    cycle(1'b0, 1'b1);
    check("en_back_release", outv(), 6'b000000);
    cycle(1'b1, 1'b1);
    check("en_back_press", outv(), 6'b100001);
    cycle(1'b0, 1'b1);
    check("en_back_rel", outv(), 6'b010000);
    cycle(1'b0, 1'b1);

    // clr while in REPEAT, released with the button still down.
    for (int j = 0; j < 13; j++) cycle(1'b1, 1'b1);
    do_reset(1'b1);
    for (int j = 0; j < 3; j++) begin
      cycle(1'b1, 1'b1);
      check("post_clr_held", outv(), 6'b000000);
    end
    cycle(1'b0, 1'b1);
    check("post_clr_release", outv(), 6'b000000);

`ifdef BTN_DBL_CLICK_EN
    cycle(1'b1, 1'b1); check("dbl_p1",      outv(), 6'b100001);
    cycle(1'b1, 1'b1);
    cycle(1'b0, 1'b1); check("dbl_r1",      outv(), 6'b010000);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b1); check("dbl_hit",     outv(), 6'b100011);
    cycle(1'b1, 1'b1);
    cycle(1'b0, 1'b1); check("dbl_r2",      outv(), 6'b010000);
    for (int j = 0; j < 5; j++) cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b1); check("dbl_expired", outv(), 6'b100001);
    cycle(1'b0, 1'b1);
    for (int j = 0; j < 8; j++) cycle(1'b0, 1'b1);
`endif

    // Random button activity with occasional disables.
    lvl = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) lvl = ~lvl;
      e = ($urandom_range(0, 39) != 0);
      cycle(lvl, e);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
